alu_wb_flags: RTL and testbench
===============================

// Module: alu_wb_flags
// PURPOSE
// Execute-to-writeback stage directly downstream of the arithmetic ALU. Registers the 8-bit ALU
// result and carry-out, derives the zero flag, owns the architectural C/Z flag registers (C feeds
// the ALU carry input), and drives the register-file write port. Holds a one-deep C/Z shadow for
// interrupt entry/return.
// PARAMETERS
// DW      8  datapath width (result, write data)
// RAW     3  register address width; address 0 is hardwired r0 (writes suppressed)
// PORTS
// clk_i       in   1    clock, rising edge
// rst_i       in   1    asynchronous reset, active-high
// valid_i     in   1    ALU output valid this cycle
// res_i       in   DW   ALU result
// cout_i      in   1    ALU carry/borrow out, already polarity-corrected
// rd_i        in   RAW  destination register
// wr_en_i     in   1    instruction writes rd
// flag_en_i   in   1    instruction updates C and Z
// stall_i     in   1    hold stage: no capture, no flag update, outputs frozen
// flush_i     in   1    kill instruction in stage
// int_save_i  in   1    interrupt entry: copy C/Z to shadow
// reti_i      in   1    interrupt return: restore C/Z from shadow
// rf_we_o     out  1    register-file write enable
// rf_addr_o   out  RAW  register-file write address
// rf_data_o   out  DW   register-file write data
// carry_o     out  1    architectural C flag (to ALU carry_i)
// zero_o      out  1    architectural Z flag
// BEHAVIOUR
// - Reset (async, rst_i=1): rf_we_o=0, rf_addr_o=0, rf_data_o=0, carry_o=0, zero_o=0, shadow C/Z=0.
// - Pipeline register, latency 1: inputs sampled at edge N appear on rf_* at edge N+1 for 1 cycle.
// - Capture when !stall_i: rf_we_o <= valid_i & wr_en_i & (rd_i!=0) & !flush_i;
//   rf_addr_o <= rd_i; rf_data_o <= res_i. Invalid/flushed cycles leave rf_we_o=0 (bubble).
// - stall_i=1: all registers hold, including flags and shadow; stall overrides flush, save, reti.
// - Flags: when !stall_i & valid_i & flag_en_i & !flush_i: carry_o <= cout_i; zero_o <= (res_i==0).
//   Z computed on full DW bits of res_i, independent of wr_en_i and rd_i (r0 compare still sets flags).
// - Shadow: int_save_i & !stall_i: shadow <= current {carry_o,zero_o} (pre-update values, even if
//   a flag update commits the same edge).
// - reti_i & !stall_i: {carry_o,zero_o} <= shadow; takes priority over a same-cycle flag update.
// - int_save_i & reti_i same cycle: illegal per control; defined as: shadow <= current flags,
//   flags <= old shadow (swap).
// - Nested interrupts unsupported: a second save overwrites shadow.
// - Reset mid-stall or mid-interrupt clears everything immediately, no pending state survives.
// TESTING
// - Reset: assert rst_i mid-cycle -> all outputs 0 without a clock edge.
// - valid, res=8'h00, cout=1, rd=3, wr_en=1, flag_en=1 -> next edge rf_we=1, addr=3, data=00, C=1, Z=1.
// - Same with rd=0 -> rf_we=0, flags still C=1 Z=1; with flush_i=1 -> rf_we=0, flags unchanged.
// - Flags C=1,Z=0; int_save_i with flag update res=8'h05,cout=0 -> flags C=0,Z=0; reti -> C=1,Z=0.
// - stall_i=1 for 3 cycles with changing inputs/reti -> rf_*, flags, shadow constant; release resumes.
// - Back-to-back valid writes r1=8'hAA, r2=8'h55 -> rf_we=1 two consecutive cycles, correct data.

Source files
------------

// File: rtl/alu_wb_flags.sv
// Execute-to-writeback stage after the ALU: registers result/carry into the register-file
// write port, owns the architectural C/Z flags and a one-deep C/Z shadow for interrupts.
module alu_wb_flags #(
  parameter int DW  = 8,
  parameter int RAW = 3
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           valid_i,
  input  logic [DW-1:0]  res_i,
  input  logic           cout_i,
  input  logic [RAW-1:0] rd_i,
  input  logic           wr_en_i,
  input  logic           flag_en_i,
  input  logic           stall_i,
  input  logic           flush_i,
  input  logic           int_save_i,
  input  logic           reti_i,
  output logic           rf_we_o,
  output logic [RAW-1:0] rf_addr_o,
  output logic [DW-1:0]  rf_data_o,
  output logic           carry_o,
  output logic           zero_o
);

  logic           rf_we_q, rf_we_d;
  logic [RAW-1:0] rf_addr_q, rf_addr_d;
  logic [DW-1:0]  rf_data_q, rf_data_d;
  logic           carry_q, carry_d;
  logic           zero_q, zero_d;
  logic           sh_carry_q, sh_carry_d;
  logic           sh_zero_q, sh_zero_d;

  logic live;
  assign live = valid_i & ~flush_i;

  always_comb begin
    rf_we_d    = rf_we_q;
    rf_addr_d  = rf_addr_q;
    rf_data_d  = rf_data_q;
    carry_d    = carry_q;
    zero_d     = zero_q;
    sh_carry_d = sh_carry_q;
    sh_zero_d  = sh_zero_q;
    if (!stall_i) begin
      rf_we_d   = live & wr_en_i & (rd_i != '0);
      rf_addr_d = rd_i;
      rf_data_d = res_i;
      // Restore beats a same-cycle flag update; save always takes pre-edge flags,
      // so save+reti together swaps flags and shadow.
      if (reti_i) begin
        carry_d = sh_carry_q;
        zero_d  = sh_zero_q;
      end else if (live & flag_en_i) begin
        carry_d = cout_i;
        zero_d  = (res_i == '0);
      end
      if (int_save_i) begin
        sh_carry_d = carry_q;
        sh_zero_d  = zero_q;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rf_we_q    <= 1'b0;
      rf_addr_q  <= '0;
      rf_data_q  <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      sh_carry_q <= 1'b0;
      sh_zero_q  <= 1'b0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_addr_q  <= rf_addr_d;
      rf_data_q  <= rf_data_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      sh_carry_q <= sh_carry_d;
      sh_zero_q  <= sh_zero_d;
    end
  end

  assign rf_we_o   = rf_we_q;
  assign rf_addr_o = rf_addr_q;
  assign rf_data_o = rf_data_q;
  assign carry_o   = carry_q;
  assign zero_o    = zero_q;

endmodule

// File: tb/tb_alu_wb_flags.sv
// Bench for alu_wb_flags: directed scenarios plus randomized traffic against a
// behavioural model of the writeback port, flags and interrupt shadow.
module tb_alu_wb_flags;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       valid_i, cout_i, wr_en_i, flag_en_i, stall_i, flush_i, int_save_i, reti_i;
  logic [7:0] res_i;
  logic [2:0] rd_i;
  logic       rf_we_o, carry_o, zero_o;
  logic [2:0] rf_addr_o;
  logic [7:0] rf_data_o;

  always #5 clk_i = ~clk_i;

  alu_wb_flags dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .res_i(res_i), .cout_i(cout_i),
    .rd_i(rd_i), .wr_en_i(wr_en_i), .flag_en_i(flag_en_i), .stall_i(stall_i),
    .flush_i(flush_i), .int_save_i(int_save_i), .reti_i(reti_i),
    .rf_we_o(rf_we_o), .rf_addr_o(rf_addr_o), .rf_data_o(rf_data_o),
    .carry_o(carry_o), .zero_o(zero_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: what the writeback port shows, the flags and the saved flags.
  logic       m_we, m_c, m_z, m_sc, m_sz;
  logic [2:0] m_addr;
  logic [7:0] m_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_we = 0; m_addr = 0; m_data = 0; m_c = 0; m_z = 0; m_sc = 0; m_sz = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_we"},   {31'd0, rf_we_o}, {31'd0, m_we});
    check({tag, "_addr"}, {29'd0, rf_addr_o}, {29'd0, m_addr});
    check({tag, "_data"}, {24'd0, rf_data_o}, {24'd0, m_data});
    check({tag, "_c"},    {31'd0, carry_o}, {31'd0, m_c});
    check({tag, "_z"},    {31'd0, zero_o},  {31'd0, m_z});
  endtask

  task automatic drive(input logic v, input logic [7:0] r, input logic co, input logic [2:0] rd,
                       input logic we, input logic fe, input logic st, input logic fl,
                       input logic sv, input logic rt);
    valid_i = v; res_i = r; cout_i = co; rd_i = rd; wr_en_i = we; flag_en_i = fe;
    stall_i = st; flush_i = fl; int_save_i = sv; reti_i = rt;
  endtask

  // One clock: advance the model from the inputs presented, then compare.
  task automatic step(input string tag);
    logic oc, oz, osc, osz;
    @(posedge clk_i);
    if (!stall_i) begin
      oc = m_c; oz = m_z; osc = m_sc; osz = m_sz;
      m_we   = valid_i && !flush_i && wr_en_i && (rd_i != 0);
      m_addr = rd_i;
      m_data = res_i;
      if (reti_i) begin
        m_c = osc; m_z = osz;
      end else if (valid_i && !flush_i && flag_en_i) begin
        m_c = cout_i; m_z = (res_i == 8'd0);
      end
      if (int_save_i) begin
        m_sc = oc; m_sz = oz;
      end
    end
    #1 check_all(tag);
  endtask

  task automatic idle();
    drive(0, 8'h00, 0, 3'd0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_i = 1'b1;
    idle();
    model_reset();
    #2 check_all("reset");
    @(negedge clk_i) rst_i = 1'b0;

    drive(1, 8'h00, 1, 3'd3, 1, 1, 0, 0, 0, 0); step("t_zero");
    check("t_zero_we_const", {31'd0, rf_we_o}, 32'd1);
    check("t_zero_addr_const", {29'd0, rf_addr_o}, 32'd3);
    check("t_zero_flags_const", {30'd0, carry_o, zero_o}, 32'd3);

    drive(1, 8'h00, 1, 3'd0, 1, 1, 0, 0, 0, 0); step("t_r0");
    check("t_r0_we_const", {31'd0, rf_we_o}, 32'd0);
    drive(1, 8'h05, 0, 3'd2, 1, 1, 0, 0, 0, 0); step("t_nz");
    drive(1, 8'h00, 1, 3'd4, 1, 1, 0, 1, 0, 0); step("t_flush");
    check("t_flush_flags_const", {30'd0, carry_o, zero_o}, 32'd0);

    drive(1, 8'h07, 1, 3'd1, 1, 1, 0, 0, 0, 0); step("t_c1z0");
    drive(1, 8'h05, 0, 3'd1, 1, 1, 0, 0, 1, 0); step("t_save");
    check("t_save_flags_const", {30'd0, carry_o, zero_o}, 32'd0);
    drive(0, 8'h00, 0, 3'd0, 0, 0, 0, 0, 0, 1); step("t_reti");
    check("t_reti_flags_const", {30'd0, carry_o, zero_o}, 32'd2);

    drive(1, 8'h00, 0, 3'd6, 1, 1, 0, 0, 1, 0); step("t_pre_stall");
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            1, 1, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
      step("t_stall");
    end
    idle(); step("t_release");
    drive(0, 8'h00, 0, 3'd0, 0, 0, 0, 0, 0, 1); step("t_stall_reti");

    drive(1, 8'hAA, 0, 3'd1, 1, 1, 0, 0, 0, 0); step("t_b2b1");
    drive(1, 8'h55, 1, 3'd2, 1, 1, 0, 0, 0, 0); step("t_b2b2");
    check("t_b2b2_data_const", {24'd0, rf_data_o}, 32'h55);
    drive(0, 8'h00, 0, 3'd0, 0, 0, 0, 0, 1, 1); step("t_swap");
    drive(0, 8'h00, 0, 3'd0, 0, 0, 0, 0, 0, 1); step("t_swap_back");

    #2 rst_i = 1'b1;
    model_reset();
    #1 check_all("t_async_rst");
    @(negedge clk_i) rst_i = 1'b0;

    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
      step("rnd");
      if ($urandom_range(0, 99) == 0) begin
        #2 rst_i = 1'b1;
        model_reset();
        #1 check_all("rnd_rst");
        @(negedge clk_i) rst_i = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
